// File: rtl/mix_pkg.sv
// mix_pkg -- shared definitions for the 8x32-bit ARX mixing round and its
// inverse. Holds the word/state types, the FSM encoding of the unmixer, the
// per-word multiplier constants K, their modular inverses KINV, and the
// additive constants C. KINV_OK is evaluated at elaboration so any edit
// that breaks K[i]*KINV[i] == 1 (mod 2^32) is caught by the tools.
package mix_pkg;

  localparam int NWORDS = 8;

  typedef logic [31:0] word_t;
  typedef word_t [NWORDS-1:0] state_t;
  typedef logic [2:0] widx_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_t;

  localparam word_t K [NWORDS] = '{
    32'd3, 32'd5, 32'd7, 32'd9, 32'd11, 32'd13, 32'd15, 32'd17
  };

  localparam word_t KINV [NWORDS] = '{
    32'hAAAAAAAB, 32'hCCCCCCCD, 32'hB6DB6DB7, 32'h38E38E39,
    32'hBA2E8BA3, 32'hC4EC4EC5, 32'hEEEEEEEF, 32'hF0F0F0F1
  };

  localparam word_t C [NWORDS] = '{
    32'd1, 32'd3, 32'd5, 32'd7, 32'd9, 32'd11, 32'd13, 32'd15
  };

  // True when every KINV entry is the multiplicative inverse of K mod 2^32.
  function automatic bit kinv_ok();
    bit ok;
    word_t prod;
    ok = 1'b1;
    for (int i = 0; i < NWORDS; i++) begin
      prod = K[i] * KINV[i];
      if (prod != 32'd1) ok = 1'b0;
    end
    return ok;
  endfunction

  localparam bit KINV_OK = kinv_ok();

endpackage

// File: rtl/mix_inv_step.sv
// mix_inv_step -- one combinational inverse word-step of the ARX round.
// Undoes s[i] = ((s[i] + s[i-1]) ^ (s[i+3] << 16)) * K[i] + C[i].
// Ports:
//   s_self  : current s[i]
//   s_fwd3  : current s[(i+3)%8]
//   s_prev  : current s[(i+7)%8]
//   idx     : word index i
//   s_new   : recovered s[i]
module mix_inv_step
  import mix_pkg::*;
(
  input  word_t s_self,
  input  word_t s_fwd3,
  input  word_t s_prev,
  input  widx_t idx,
  output word_t s_new
);

  word_t t_mul;
  word_t t_mix;

  // Multiplying by KINV undoes the odd multiplier exactly, since the
  // product is taken modulo 2^32.
  always_comb begin
    t_mul = (s_self - C[idx]) * KINV[idx];
    t_mix = t_mul ^ (s_fwd3 << 16);
    s_new = t_mix - s_prev;
  end

endmodule

// File: rtl/mix_unround.sv
// mix_unround -- recovers the pre-mix 256-bit state from the forward ARX
// mixer output, one word-step per clock, undoing ROUNDS rounds.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : input handshake, in_ready high only in IDLE
//   in_data             : mixed state, word i at [32i+31:32i]
//   out_valid/out_ready : output handshake, out_valid high in DONE
//   out_data            : recovered state, same packing
//   busy                : high while steps are being applied
module mix_unround
  import mix_pkg::*;
#(
  parameter int ROUNDS = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [255:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] out_data,
  output logic         busy
);

  if (ROUNDS < 1 || ROUNDS > 16) begin : g_bad_rounds
    $error("mix_unround: ROUNDS must be in 1..16");
  end
  if (!KINV_OK) begin : g_bad_kinv
    $error("mix_pkg: KINV is not the inverse of K mod 2^32");
  end

  localparam logic [3:0] RND_LAST = 4'(ROUNDS - 1);

  fsm_t       state;
  fsm_t       state_nxt;
  state_t     st;
  widx_t      idx;
  widx_t      idx_fwd3;
  widx_t      idx_prev;
  logic [3:0] rnd;
  word_t      step_new;
  logic       last_step;

  // Neighbour indices wrap naturally in 3-bit arithmetic.
  assign idx_fwd3  = idx + 3'd3;
  assign idx_prev  = idx - 3'd1;
  assign last_step = (idx == 3'd0) && (rnd == RND_LAST);

  mix_inv_step u_step (
    .s_self (st[idx]),
    .s_fwd3 (st[idx_fwd3]),
    .s_prev (st[idx_prev]),
    .idx    (idx),
    .s_new  (step_new)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = RUN;
      RUN:     if (last_step) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state == RUN);
  assign out_valid = (state == DONE);
  assign out_data  = st;

  // Steps run from word 7 down to word 0; each step rewrites only s[idx]
  // while the neighbours are read from the live register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st  <= '0;
      idx <= 3'd7;
      rnd <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            st  <= in_data;
            idx <= 3'd7;
            rnd <= 4'd0;
          end
        end
        RUN: begin
          st[idx] <= step_new;
          if (idx == 3'd0) begin
            if (!last_step) begin
              idx <= 3'd7;
              rnd <= rnd + 4'd1;
            end
          end else begin
            idx <= idx - 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mix_unround.sv
// tb_mix_unround -- directed bench for mix_unround with three instances
// (ROUNDS = 1, 3, 16) sharing clock and reset. Expected results come from a
// hand-computed vector and from a forward-round model of the mixer.
module tb_mix_unround;

  localparam int RT [3] = '{1, 3, 16};

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid  [3];
  logic         in_ready  [3];
  logic [255:0] in_data   [3];
  logic         out_valid [3];
  logic         out_ready [3];
  logic [255:0] out_data  [3];
  logic         busy      [3];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mix_unround #(.ROUNDS(1)) u_r1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
    .busy(busy[0])
  );
  mix_unround #(.ROUNDS(3)) u_r3 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
    .busy(busy[1])
  );
  mix_unround #(.ROUNDS(16)) u_r16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_data(in_data[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(out_data[2]),
    .busy(busy[2])
  );

  // Forward mixing round, straight from the reference definition.
  function automatic logic [255:0] fwd(input logic [255:0] x, input int r);
    logic [31:0] s [8];
    logic [31:0] kk [8];
    logic [31:0] t;
    logic [255:0] y;
    kk = '{32'd3, 32'd5, 32'd7, 32'd9, 32'd11, 32'd13, 32'd15, 32'd17};
    for (int i = 0; i < 8; i++) s[i] = x[32*i +: 32];
    for (int rr = 0; rr < r; rr++) begin
      for (int i = 0; i < 8; i++) begin
        t = s[i] + s[(i+7)%8];
        t = t ^ (s[(i+3)%8] << 16);
        s[i] = t * kk[i] + 32'(2*i + 1);
      end
    end
    for (int i = 0; i < 8; i++) y[32*i +: 32] = s[i];
    return y;
  endfunction

  function automatic logic [255:0] rand_state();
    logic [255:0] y;
    for (int i = 0; i < 8; i++) y[32*i +: 32] = $urandom;
    return y;
  endfunction

  task automatic do_txn(input int k, input logic [255:0] din,
                        input logic [255:0] exp, input string name);
    int cyc;
    tests++;
    if (in_ready[k] !== 1'b1) begin
      fails++;
      $display("FAIL %s in_ready before accept: got %b want 1", name, in_ready[k]);
    end
    in_valid[k] = 1'b1;
    in_data[k]  = din;
    @(posedge clk); #1;
    in_valid[k] = 1'b0;
    tests++;
    if (busy[k] !== 1'b1) begin
      fails++;
      $display("FAIL %s busy after accept: got %b want 1", name, busy[k]);
    end
    cyc = 0;
    while (out_valid[k] !== 1'b1 && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
    end
    tests++;
    if (cyc != 8*RT[k]) begin
      fails++;
      $display("FAIL %s latency: got %0d want %0d", name, cyc, 8*RT[k]);
    end
    tests++;
    if (out_data[k] !== exp) begin
      fails++;
      $display("FAIL %s out_data: got %h want %h", name, out_data[k], exp);
    end
    out_ready[k] = 1'b1;
    @(posedge clk); #1;
    out_ready[k] = 1'b0;
    tests++;
    if (out_valid[k] !== 1'b0 || in_ready[k] !== 1'b1) begin
      fails++;
      $display("FAIL %s after out handshake: out_valid=%b in_ready=%b want 0/1",
               name, out_valid[k], in_ready[k]);
    end
  endtask

  task automatic test_reset();
    for (int pass = 0; pass < 2; pass++) begin
      for (int k = 0; k < 3; k++) begin
        tests++;
        if (in_ready[k] !== 1'b1 || out_valid[k] !== 1'b0 || busy[k] !== 1'b0 ||
            out_data[k] !== 256'd0) begin
          fails++;
          $display("FAIL reset_values[%0d] pass %0d: rdy=%b vld=%b busy=%b data=%h want 1/0/0/0",
                   k, pass, in_ready[k], out_valid[k], busy[k], out_data[k]);
        end
      end
      if (pass == 0) begin
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
      end
    end
  endtask

  task automatic test_known_vector();
    logic [255:0] v;
    v = {32'd107208152, 32'd6109753, 32'd931604, 32'd6125,
         32'd556, 32'd61, 32'd8, 32'd1};
    do_txn(0, v, 256'd0, "known_vector");
  endtask

  task automatic test_roundtrip();
    logic [255:0] o;
    for (int k = 0; k < 3; k++) begin
      for (int n = 0; n < 2; n++) begin
        o = rand_state();
        do_txn(k, fwd(o, RT[k]), o, $sformatf("roundtrip_r%0d_%0d", RT[k], n));
      end
    end
  endtask

  task automatic test_wrap();
    logic [255:0] pats [3];
    pats[0] = {8{32'hFFFFFFFF}};
    pats[1] = {8{32'h80000000}};
    pats[2] = {32'h80000001, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF,
               32'hFFFF0000, 32'h8000FFFF, 32'h00000000, 32'hFFFFFFFE};
    for (int k = 0; k < 3; k++)
      for (int p = 0; p < 3; p++)
        do_txn(k, fwd(pats[p], RT[k]), pats[p], $sformatf("wrap_r%0d_p%0d", RT[k], p));
  endtask

  task automatic test_hold();
    logic [255:0] o;
    int cyc;
    o = rand_state();
    in_valid[0] = 1'b1;
    in_data[0]  = fwd(o, 1);
    @(posedge clk); #1;
    in_data[0] = rand_state();
    cyc = 0;
    while (out_valid[0] !== 1'b1 && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      tests++;
      if (out_valid[0] !== 1'b1 || in_ready[0] !== 1'b0 || out_data[0] !== o) begin
        fails++;
        $display("FAIL hold cycle %0d: vld=%b rdy=%b data=%h want 1/0/%h",
                 c, out_valid[0], in_ready[0], out_data[0], o);
      end
    end
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    out_ready[0] = 1'b0;
    tests++;
    if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0 || out_data[0] !== o) begin
      fails++;
      $display("FAIL hold release: rdy=%b vld=%b data=%h want 1/0/%h",
               in_ready[0], out_valid[0], out_data[0], o);
    end
  endtask

  task automatic test_back_to_back(input int k);
    logic [255:0] o [4];
    logic [255:0] cap;
    logic acc, outh;
    int sent, got, last_acc, cyc, extra;
    for (int n = 0; n < 4; n++) o[n] = rand_state();
    sent = 0; got = 0; last_acc = 0; cyc = 0; extra = 0;
    out_ready[k] = 1'b1;
    in_valid[k]  = 1'b1;
    in_data[k]   = fwd(o[0], RT[k]);
    while (got < 4 && cyc < 4*(8*RT[k]+2) + 40) begin
      acc  = in_valid[k] && in_ready[k];
      outh = out_valid[k] && out_ready[k];
      cap  = out_data[k];
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        if (sent > 0) begin
          tests++;
          if (cyc - last_acc != 8*RT[k]+2) begin
            fails++;
            $display("FAIL b2b_r%0d accept interval: got %0d want %0d",
                     RT[k], cyc - last_acc, 8*RT[k]+2);
          end
        end
        last_acc = cyc;
        sent++;
        if (sent < 4) in_data[k] = fwd(o[sent], RT[k]);
        else          in_valid[k] = 1'b0;
      end
      if (outh) begin
        tests++;
        if (got >= sent || cap !== o[got]) begin
          fails++;
          $display("FAIL b2b_r%0d result %0d: got %h want %h", RT[k], got, cap, o[got]);
        end
        got++;
      end
    end
    for (int c = 0; c < 8*RT[k]+4; c++) begin
      @(posedge clk); #1;
      if (out_valid[k] === 1'b1) extra++;
    end
    out_ready[k] = 1'b0;
    in_valid[k]  = 1'b0;
    tests++;
    if (sent != 4 || got != 4 || extra != 0) begin
      fails++;
      $display("FAIL b2b_r%0d counts: sent=%0d got=%0d extra=%0d want 4/4/0",
               RT[k], sent, got, extra);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [255:0] o;
    int spurious;
    o = rand_state();
    in_valid[0] = 1'b1;
    in_data[0]  = fwd(o, 1);
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0 || busy[0] !== 1'b0 ||
        out_data[0] !== 256'd0) begin
      fails++;
      $display("FAIL mid_reset values: rdy=%b vld=%b busy=%b data=%h want 1/0/0/0",
               in_ready[0], out_valid[0], busy[0], out_data[0]);
    end
    #2;
    rst_n = 1'b1;
    spurious = 0;
    for (int c = 0; c < 16; c++) begin
      @(posedge clk); #1;
      if (out_valid[0] === 1'b1 || busy[0] === 1'b1) spurious++;
    end
    tests++;
    if (spurious != 0) begin
      fails++;
      $display("FAIL mid_reset no output: got %0d active cycles want 0", spurious);
    end
    o = rand_state();
    do_txn(0, fwd(o, 1), o, "after_mid_reset");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid[k]  = 1'b0;
      out_ready[k] = 1'b0;
      in_data[k]   = '0;
    end
    #1;
    test_reset();
    @(posedge clk); #1;
    test_known_vector();
    test_roundtrip();
    test_wrap();
    test_hold();
    test_back_to_back(0);
    test_back_to_back(1);
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mix_unround.md
# mix_unround

Inverse of the team's 8×32-bit ARX mixing round: accepts a 256-bit mixed state over a valid/ready handshake and recovers the pre-mix state one word-step per clock. It sits on the consumer side of the mixing datapath, directly after the forward mixer. The forward mixer and `mix_unround` compose to identity for every input and every `ROUNDS` value.

## Interface
- `ROUNDS`, default 1: number of forward rounds to undo. Legal range is 1..16.
- `clk` input 1: single clock. All logic updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: `in_data` is valid.
- `in_ready` output 1: block can accept a state. High only in IDLE.
- `in_data` input 256: mixed state. Word i occupies bits [32i+31:32i].
- `out_valid` output 1: `out_data` holds the recovered state.
- `out_ready` input 1: downstream accepts `out_data`.
- `out_data` output 256: recovered state, same word packing as `in_data`.
- `busy` output 1: high in RUN.

## Operation
- Forward step i (reference definition, i = 0..7 in order, all arithmetic mod 2^32):
  - t = s[i] + s[(i+7)%8]
  - t ^= s[(i+3)%8] << 16
  - s[i] = t·K[i] + C[i]
- Forward round constants:
  - K = 3, 5, 7, 9, 11, 13, 15, 17.
  - C[i] = 2i+1.
- Inverse step i, applied for i = 7 down to 0 in each round, once per round for `ROUNDS` rounds:
  - t = (s[i] − C[i])·KINV[i], truncated to 32 bits
  - t ^= s[(i+3)%8] << 16
  - s[i] = t − s[(i+7)%8]
- Inverse constants:
  - KINV = 0xAAAAAAAB, 0xCCCCCCCD, 0xB6DB6DB7, 0x38E38E39, 0xBA2E8BA3, 0xC4EC4EC5, 0xEEEEEEEF, 0xF0F0F0F1.
- Each step modifies only s[i]. Neighbour reads use the current register contents.
- All products are 32×32 multiplies truncated to the low 32 bits. Subtraction wraps.
- FSM has three states:
  - IDLE: `in_ready`=1. When `in_valid`&&`in_ready`, load `in_data` into the state register, set idx=7 and rnd=0, and go to RUN.
  - RUN: on each clock apply inverse step idx.
    - If idx=0 and rnd=ROUNDS−1, go to DONE.
    - Otherwise, if idx=0, set idx=7 and increment rnd.
    - Otherwise, decrement idx.
  - DONE: `out_valid`=1 and `out_data` is stable. When `out_ready`, go to IDLE.
- Input handshakes presented in RUN or DONE are not accepted (`in_ready`=0). Upstream must hold its data.
- Reset values: state IDLE, `in_ready`=1, `out_valid`=0, `busy`=0, `out_data`=0, idx=7, rnd=0.

## Timing
- Accept on edge N.
- RUN executes on edges N+1 .. N+8·ROUNDS.
- `out_valid` rises after edge N+8·ROUNDS. For ROUNDS=1 the latency is 8 cycles.
- `out_valid` and `out_data` hold until the edge where `out_ready`=1.
- `in_ready` rises in the cycle after the output handshake. Peak throughput is one state per 8·ROUNDS+2 cycles.
- `out_ready` held high before DONE has no effect. DONE still lasts at least one cycle.
- If `rst_n` is asserted at any time (mid-RUN or in DONE), all state returns to reset values immediately. The partial result is discarded and no `out_valid` pulse appears.
- On `rst_n` deassertion, the first accept can occur on the first rising edge.

## Structure
- Package `mix_pkg` holds:
  - `NWORDS`=8.
  - `word_t` (32-bit).
  - `state_t` (8 × `word_t`).
  - K, KINV and C arrays.
  - An elaboration-time check that K[i]·KINV[i] mod 2^32 = 1.
- The forward mixer shares this package.
- Sub-module `mix_inv_step` (combinational): its inputs are s[i], s[(i+3)%8], s[(i+7)%8] and i, and its output is the new s[i]. The top-level holds the FSM, counters and state register.

## Test plan
- ROUNDS=1, input {1, 8, 61, 556, 6125, 931604, 6109753, 107208152} (words 0..7) -> after 8 cycles, `out_data` is all zeros and `out_valid`=1.
- Random 256-bit states, ROUNDS ∈ {1, 3, 16}, passed through a reference forward model -> `out_data` equals the original state. Latency is exactly 8·ROUNDS cycles.
- `out_ready` held low for 20 cycles in DONE -> `out_data` stays stable, `in_ready`=0, and a new `in_valid` is ignored.
- Back-to-back inputs with `out_ready`=1 -> one accept every 8·ROUNDS+2 cycles, with no loss or duplication.
- `rst_n` asserted on RUN cycle 4 -> outputs go to reset values immediately and no `out_valid` is produced. The next transaction is correct.
- Words 0xFFFFFFFF and words with 0x80000000 set -> wrap-around correct and round-trip identity holds.
